// File: rtl/axi4_lite_arbiter_m2s1.sv
// Two-master to one-slave AXI4-Lite arbiter. Write and read paths are arbitrated
// independently with round-robin priority and hold one transaction each.
module axi4_lite_arbiter_m2s1 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    m0_AWVALID,
  input  logic [ADDR_WIDTH-1:0]   m0_AWADDR,
  output logic                    m0_AWREADY,
  input  logic                    m0_WVALID,
  input  logic [DATA_WIDTH-1:0]   m0_WDATA,
  input  logic [DATA_WIDTH/8-1:0] m0_WSTRB,
  output logic                    m0_WREADY,
  output logic                    m0_BVALID,
  output logic [1:0]              m0_BRESP,
  input  logic                    m0_BREADY,
  input  logic                    m0_ARVALID,
  input  logic [ADDR_WIDTH-1:0]   m0_ARADDR,
  output logic                    m0_ARREADY,
  output logic                    m0_RVALID,
  output logic [DATA_WIDTH-1:0]   m0_RDATA,
  output logic [1:0]              m0_RRESP,
  input  logic                    m0_RREADY,
  input  logic                    m1_AWVALID,
  input  logic [ADDR_WIDTH-1:0]   m1_AWADDR,
  output logic                    m1_AWREADY,
  input  logic                    m1_WVALID,
  input  logic [DATA_WIDTH-1:0]   m1_WDATA,
  input  logic [DATA_WIDTH/8-1:0] m1_WSTRB,
  output logic                    m1_WREADY,
  output logic                    m1_BVALID,
  output logic [1:0]              m1_BRESP,
  input  logic                    m1_BREADY,
  input  logic                    m1_ARVALID,
  input  logic [ADDR_WIDTH-1:0]   m1_ARADDR,
  output logic                    m1_ARREADY,
  output logic                    m1_RVALID,
  output logic [DATA_WIDTH-1:0]   m1_RDATA,
  output logic [1:0]              m1_RRESP,
  input  logic                    m1_RREADY,
  output logic                    s_AWVALID,
  output logic [ADDR_WIDTH-1:0]   s_AWADDR,
  input  logic                    s_AWREADY,
  output logic                    s_WVALID,
  output logic [DATA_WIDTH-1:0]   s_WDATA,
  output logic [DATA_WIDTH/8-1:0] s_WSTRB,
  input  logic                    s_WREADY,
  input  logic                    s_BVALID,
  input  logic [1:0]              s_BRESP,
  output logic                    s_BREADY,
  output logic                    s_ARVALID,
  output logic [ADDR_WIDTH-1:0]   s_ARADDR,
  input  logic                    s_ARREADY,
  input  logic                    s_RVALID,
  input  logic [DATA_WIDTH-1:0]   s_RDATA,
  input  logic [1:0]              s_RRESP,
  output logic                    s_RREADY,
  output logic [1:0]              oWGNT,
  output logic [1:0]              oRGNT
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  logic                  m_awvalid [2];
  logic [ADDR_WIDTH-1:0] m_awaddr  [2];
  logic                  m_awready [2];
  logic                  m_wvalid  [2];
  logic [DATA_WIDTH-1:0] m_wdata   [2];
  logic [STRB_WIDTH-1:0] m_wstrb   [2];
  logic                  m_wready  [2];
  logic                  m_bvalid  [2];
  logic [1:0]            m_bresp   [2];
  logic                  m_bready  [2];
  logic                  m_arvalid [2];
  logic [ADDR_WIDTH-1:0] m_araddr  [2];
  logic                  m_arready [2];
  logic                  m_rvalid  [2];
  logic [DATA_WIDTH-1:0] m_rdata   [2];
  logic [1:0]            m_rresp   [2];
  logic                  m_rready  [2];

  assign m_awvalid[0] = m0_AWVALID;  assign m_awvalid[1] = m1_AWVALID;
  assign m_awaddr[0]  = m0_AWADDR;   assign m_awaddr[1]  = m1_AWADDR;
  assign m_wvalid[0]  = m0_WVALID;   assign m_wvalid[1]  = m1_WVALID;
  assign m_wdata[0]   = m0_WDATA;    assign m_wdata[1]   = m1_WDATA;
  assign m_wstrb[0]   = m0_WSTRB;    assign m_wstrb[1]   = m1_WSTRB;
  assign m_bready[0]  = m0_BREADY;   assign m_bready[1]  = m1_BREADY;
  assign m_arvalid[0] = m0_ARVALID;  assign m_arvalid[1] = m1_ARVALID;
  assign m_araddr[0]  = m0_ARADDR;   assign m_araddr[1]  = m1_ARADDR;
  assign m_rready[0]  = m0_RREADY;   assign m_rready[1]  = m1_RREADY;

  // ---------------- write path ----------------
  w_state_t   w_state_q, w_state_d;
  logic [1:0] w_gnt_q, w_gnt_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       w_last_q, w_last_d;

  logic       w_sel, w_busy, w_addr_ph, w_resp_ph;
  logic       aw_hs, w_hs, b_hs;
  logic [1:0] w_req;

  assign w_sel     = w_gnt_q[1];
  assign w_busy    = |w_gnt_q;
  assign w_addr_ph = (w_state_q == W_ADDR);
  assign w_resp_ph = (w_state_q == W_RESP);
  assign w_req     = {m_awvalid[1] | m_wvalid[1], m_awvalid[0] | m_wvalid[0]};

  assign s_AWVALID = w_addr_ph & m_awvalid[w_sel] & ~aw_done_q;
  assign s_WVALID  = w_addr_ph & m_wvalid[w_sel] & ~w_done_q;
  assign s_BREADY  = w_resp_ph & m_bready[w_sel];
  assign s_AWADDR  = w_busy ? m_awaddr[w_sel] : '0;
  assign s_WDATA   = w_busy ? m_wdata[w_sel] : '0;
  assign s_WSTRB   = w_busy ? m_wstrb[w_sel] : '0;

  assign aw_hs = s_AWVALID & s_AWREADY;
  assign w_hs  = s_WVALID & s_WREADY;
  assign b_hs  = s_BVALID & s_BREADY;

  always_comb begin
    w_state_d = w_state_q;
    w_gnt_d   = w_gnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    w_last_d  = w_last_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (w_req != 2'b00) begin
          // On a tie the master that was not served last wins.
          w_gnt_d   = (w_req == 2'b11) ? (w_last_q ? 2'b01 : 2'b10) : w_req;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (b_hs) begin
          w_last_d  = w_sel;
          w_gnt_d   = 2'b00;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_gnt_d   = 2'b00;
        w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      w_state_q <= W_IDLE;
      w_gnt_q   <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      w_last_q  <= 1'b1;
    end else begin
      w_state_q <= w_state_d;
      w_gnt_q   <= w_gnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      w_last_q  <= w_last_d;
    end
  end

  // ---------------- read path ----------------
  r_state_t   r_state_q, r_state_d;
  logic [1:0] r_gnt_q, r_gnt_d;
  logic       r_last_q, r_last_d;

  logic       r_sel, r_busy, r_addr_ph, r_data_ph;
  logic       ar_hs, r_hs;
  logic [1:0] r_req;

  assign r_sel     = r_gnt_q[1];
  assign r_busy    = |r_gnt_q;
  assign r_addr_ph = (r_state_q == R_ADDR);
  assign r_data_ph = (r_state_q == R_DATA);
  assign r_req     = {m_arvalid[1], m_arvalid[0]};

  assign s_ARVALID = r_addr_ph & m_arvalid[r_sel];
  assign s_RREADY  = r_data_ph & m_rready[r_sel];
  assign s_ARADDR  = r_busy ? m_araddr[r_sel] : '0;

  assign ar_hs = s_ARVALID & s_ARREADY;
  assign r_hs  = s_RVALID & s_RREADY;

  always_comb begin
    r_state_d = r_state_q;
    r_gnt_d   = r_gnt_q;
    r_last_d  = r_last_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (r_req != 2'b00) begin
          r_gnt_d   = (r_req == 2'b11) ? (r_last_q ? 2'b01 : 2'b10) : r_req;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (ar_hs) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (r_hs) begin
          r_last_d  = r_sel;
          r_gnt_d   = 2'b00;
          r_state_d = R_IDLE;
        end
      end
      default: begin
        r_gnt_d   = 2'b00;
        r_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_state_q <= R_IDLE;
      r_gnt_q   <= 2'b00;
      r_last_q  <= 1'b1;
    end else begin
      r_state_q <= r_state_d;
      r_gnt_q   <= r_gnt_d;
      r_last_q  <= r_last_d;
    end
  end

  // Upstream returns: only the granted master sees the slave; the other reads all zero.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign m_awready[gi] = w_addr_ph & w_gnt_q[gi] & ~aw_done_q & s_AWREADY;
    assign m_wready[gi]  = w_addr_ph & w_gnt_q[gi] & ~w_done_q & s_WREADY;
    assign m_bvalid[gi]  = w_resp_ph & w_gnt_q[gi] & s_BVALID;
    assign m_bresp[gi]   = (w_resp_ph & w_gnt_q[gi]) ? s_BRESP : 2'b00;
    assign m_arready[gi] = r_addr_ph & r_gnt_q[gi] & s_ARREADY;
    assign m_rvalid[gi]  = r_data_ph & r_gnt_q[gi] & s_RVALID;
    assign m_rdata[gi]   = (r_data_ph & r_gnt_q[gi]) ? s_RDATA : '0;
    assign m_rresp[gi]   = (r_data_ph & r_gnt_q[gi]) ? s_RRESP : 2'b00;
  end

  assign m0_AWREADY = m_awready[0];  assign m1_AWREADY = m_awready[1];
  assign m0_WREADY  = m_wready[0];   assign m1_WREADY  = m_wready[1];
  assign m0_BVALID  = m_bvalid[0];   assign m1_BVALID  = m_bvalid[1];
  assign m0_BRESP   = m_bresp[0];    assign m1_BRESP   = m_bresp[1];
  assign m0_ARREADY = m_arready[0];  assign m1_ARREADY = m_arready[1];
  assign m0_RVALID  = m_rvalid[0];   assign m1_RVALID  = m_rvalid[1];
  assign m0_RDATA   = m_rdata[0];    assign m1_RDATA   = m_rdata[1];
  assign m0_RRESP   = m_rresp[0];    assign m1_RRESP   = m_rresp[1];

  assign oWGNT = w_gnt_q;
  assign oRGNT = r_gnt_q;

endmodule

// File: tb/tb_axi4_lite_arbiter_m2s1.sv
// Randomized bench: two AXI-obeying masters and a reactive slave, every cycle
// compared against a transaction-level reference of the arbitration rules.
module tb_axi4_lite_arbiter_m2s1;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int NCYC = 1500;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  always #5 iCLK = ~iCLK;

  logic          m_awvalid [2];
  logic [AW-1:0] m_awaddr  [2];
  logic          m_awready [2];
  logic          m_wvalid  [2];
  logic [DW-1:0] m_wdata   [2];
  logic [SW-1:0] m_wstrb   [2];
  logic          m_wready  [2];
  logic          m_bvalid  [2];
  logic [1:0]    m_bresp   [2];
  logic          m_bready  [2];
  logic          m_arvalid [2];
  logic [AW-1:0] m_araddr  [2];
  logic          m_arready [2];
  logic          m_rvalid  [2];
  logic [DW-1:0] m_rdata   [2];
  logic [1:0]    m_rresp   [2];
  logic          m_rready  [2];

  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic [1:0]    s_bresp, s_rresp;
  logic [1:0]    o_wgnt, o_rgnt;

  axi4_lite_arbiter_m2s1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .m0_AWVALID(m_awvalid[0]), .m0_AWADDR(m_awaddr[0]), .m0_AWREADY(m_awready[0]),
    .m0_WVALID(m_wvalid[0]), .m0_WDATA(m_wdata[0]), .m0_WSTRB(m_wstrb[0]), .m0_WREADY(m_wready[0]),
    .m0_BVALID(m_bvalid[0]), .m0_BRESP(m_bresp[0]), .m0_BREADY(m_bready[0]),
    .m0_ARVALID(m_arvalid[0]), .m0_ARADDR(m_araddr[0]), .m0_ARREADY(m_arready[0]),
    .m0_RVALID(m_rvalid[0]), .m0_RDATA(m_rdata[0]), .m0_RRESP(m_rresp[0]), .m0_RREADY(m_rready[0]),
    .m1_AWVALID(m_awvalid[1]), .m1_AWADDR(m_awaddr[1]), .m1_AWREADY(m_awready[1]),
    .m1_WVALID(m_wvalid[1]), .m1_WDATA(m_wdata[1]), .m1_WSTRB(m_wstrb[1]), .m1_WREADY(m_wready[1]),
    .m1_BVALID(m_bvalid[1]), .m1_BRESP(m_bresp[1]), .m1_BREADY(m_bready[1]),
    .m1_ARVALID(m_arvalid[1]), .m1_ARADDR(m_araddr[1]), .m1_ARREADY(m_arready[1]),
    .m1_RVALID(m_rvalid[1]), .m1_RDATA(m_rdata[1]), .m1_RRESP(m_rresp[1]), .m1_RREADY(m_rready[1]),
    .s_AWVALID(s_awvalid), .s_AWADDR(s_awaddr), .s_AWREADY(s_awready),
    .s_WVALID(s_wvalid), .s_WDATA(s_wdata), .s_WSTRB(s_wstrb), .s_WREADY(s_wready),
    .s_BVALID(s_bvalid), .s_BRESP(s_bresp), .s_BREADY(s_bready),
    .s_ARVALID(s_arvalid), .s_ARADDR(s_araddr), .s_ARREADY(s_arready),
    .s_RVALID(s_rvalid), .s_RDATA(s_rdata), .s_RRESP(s_rresp), .s_RREADY(s_rready),
    .oWGNT(o_wgnt), .oRGNT(o_rgnt)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Master-side transaction state and held payloads.
  bit            wa [2], awp [2], wp [2], ra [2], arp [2];
  int            awd [2], wd [2];
  logic [AW-1:0] maw [2], mar [2];
  logic [DW-1:0] mwd [2];
  logic [SW-1:0] mws [2];

  // Slave-side state.
  bit            sl_aw, sl_w, sl_b, sl_r;
  int            sl_bd, sl_rd, stall;
  logic [1:0]    sl_bresp, sl_rresp;
  logic [DW-1:0] sl_rdata;

  // Reference: owner (-1 = none), phase (0 address, 1 response), last-served master.
  int wo, ro, wprev, rprev;
  bit wph, awt, wt, rph;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic reset_model();
    wo = -1; ro = -1; wprev = 1; rprev = 1;
    wph = 1'b0; awt = 1'b0; wt = 1'b0; rph = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wa[i] = 1'b0; awp[i] = 1'b0; wp[i] = 1'b0; ra[i] = 1'b0; arp[i] = 1'b0;
      awd[i] = 0; wd[i] = 0;
      maw[i] = '0; mar[i] = '0; mwd[i] = '0; mws[i] = '0;
    end
    sl_aw = 1'b0; sl_w = 1'b0; sl_b = 1'b0; sl_r = 1'b0;
    sl_bd = 0; sl_rd = 0; stall = 0;
    sl_bresp = 2'b00; sl_rresp = 2'b00; sl_rdata = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      m_awvalid[i] = wa[i] && awp[i] && (awd[i] == 0);
      m_awaddr[i]  = m_awvalid[i] ? maw[i] : AW'($urandom);
      m_wvalid[i]  = wa[i] && wp[i] && (wd[i] == 0);
      m_wdata[i]   = m_wvalid[i] ? mwd[i] : DW'($urandom);
      m_wstrb[i]   = m_wvalid[i] ? mws[i] : SW'($urandom);
      m_bready[i]  = 1'($urandom_range(0, 1));
      m_arvalid[i] = ra[i] && arp[i];
      m_araddr[i]  = m_arvalid[i] ? mar[i] : AW'($urandom);
      m_rready[i]  = 1'($urandom_range(0, 1));
    end
    s_awready = (stall == 0) && ($urandom_range(0, 9) < 6);
    s_wready  = (stall == 0) && ($urandom_range(0, 9) < 6);
    s_arready = (stall == 0) && ($urandom_range(0, 9) < 6);
    s_bvalid  = sl_b && (sl_bd == 0);
    s_bresp   = s_bvalid ? sl_bresp : 2'($urandom);
    s_rvalid  = sl_r && (sl_rd == 0);
    s_rdata   = s_rvalid ? sl_rdata : DW'($urandom);
    s_rresp   = s_rvalid ? sl_rresp : 2'($urandom);
  endtask

  task automatic step_cycle();
    int g, h;
    bit waddr, wresp, raddr, rdat, req0, req1;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic e_saw, e_sw, e_sb, e_sar, e_sr;
    logic [4:0] e_mctl;
    logic [3:0] e_resp;
    logic [DW-1:0] e_rdata;

    g = (wo < 0) ? 0 : wo;
    h = (ro < 0) ? 0 : ro;
    waddr = (wo >= 0) && !wph;
    wresp = (wo >= 0) && wph;
    raddr = (ro >= 0) && !rph;
    rdat  = (ro >= 0) && rph;

    e_saw = waddr && m_awvalid[g] && !awt;
    e_sw  = waddr && m_wvalid[g] && !wt;
    e_sb  = wresp && m_bready[g];
    e_sar = raddr && m_arvalid[h];
    e_sr  = rdat && m_rready[h];

    check_eq("oWGNT", o_wgnt, (wo < 0) ? 2'b00 : ((wo == 0) ? 2'b01 : 2'b10));
    check_eq("oRGNT", o_rgnt, (ro < 0) ? 2'b00 : ((ro == 0) ? 2'b01 : 2'b10));
    check_eq("s_ctl", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready},
             {e_saw, e_sw, e_sb, e_sar, e_sr});
    for (int i = 0; i < 2; i++) begin
      e_mctl  = {waddr && (wo == i) && s_awready && !awt,
                 waddr && (wo == i) && s_wready && !wt,
                 wresp && (wo == i) && s_bvalid,
                 raddr && (ro == i) && s_arready,
                 rdat && (ro == i) && s_rvalid};
      e_resp  = {(rdat && (ro == i)) ? s_rresp : 2'b00, (wresp && (wo == i)) ? s_bresp : 2'b00};
      e_rdata = (rdat && (ro == i)) ? s_rdata : DW'(0);
      check_eq($sformatf("m%0d_ctl", i),
               {m_awready[i], m_wready[i], m_bvalid[i], m_arready[i], m_rvalid[i]}, e_mctl);
      check_eq($sformatf("m%0d_resp", i), {m_rresp[i], m_bresp[i]}, e_resp);
      check_eq($sformatf("m%0d_rdata", i), m_rdata[i], e_rdata);
    end
    check_eq("s_awaddr", s_awaddr, (wo >= 0) ? m_awaddr[g] : AW'(0));
    check_eq("s_wpayload", {s_wstrb, s_wdata}, (wo >= 0) ? {m_wstrb[g], m_wdata[g]} : {SW'(0), DW'(0)});
    check_eq("s_araddr", s_araddr, (ro >= 0) ? m_araddr[h] : AW'(0));

    aw_hs = e_saw && s_awready;
    w_hs  = e_sw && s_wready;
    b_hs  = s_bvalid && e_sb;
    ar_hs = e_sar && s_arready;
    r_hs  = s_rvalid && e_sr;

    if (aw_hs) awp[g] = 1'b0;
    if (w_hs)  wp[g]  = 1'b0;
    if (b_hs) begin
      wa[g] = 1'b0;
      $display("cycle %0d: write m%0d addr=%h data=%h strb=%h bresp=%0d",
               cyc, g, maw[g], mwd[g], mws[g], s_bresp);
    end
    if (ar_hs) arp[h] = 1'b0;
    if (r_hs) begin
      ra[h] = 1'b0;
      $display("cycle %0d: read  m%0d addr=%h data=%h rresp=%0d", cyc, h, mar[h], s_rdata, s_rresp);
    end

    if (sl_bd > 0) sl_bd--;
    if (sl_rd > 0) sl_rd--;
    if (aw_hs) sl_aw = 1'b1;
    if (w_hs)  sl_w  = 1'b1;
    if (b_hs)  sl_b  = 1'b0;
    if (sl_aw && sl_w) begin
      sl_aw = 1'b0; sl_w = 1'b0; sl_b = 1'b1;
      sl_bd = $urandom_range(0, 6);
      sl_bresp = 2'($urandom);
    end
    if (r_hs) sl_r = 1'b0;
    if (ar_hs) begin
      sl_r = 1'b1;
      sl_rd = $urandom_range(0, 6);
      sl_rdata = DW'($urandom);
      sl_rresp = 2'($urandom);
    end
    if (stall > 0) stall--;
    else if ($urandom_range(0, 39) == 0) stall = 5;

    req0 = m_awvalid[0] || m_wvalid[0];
    req1 = m_awvalid[1] || m_wvalid[1];
    if (wo < 0) begin
      if (req0 || req1) begin
        wo = (req0 && req1) ? ((wprev == 1) ? 0 : 1) : (req0 ? 0 : 1);
        wph = 1'b0; awt = 1'b0; wt = 1'b0;
      end
    end else if (!wph) begin
      awt = awt || aw_hs;
      wt  = wt || w_hs;
      if (awt && wt) wph = 1'b1;
    end else if (b_hs) begin
      wprev = wo; wo = -1;
    end

    if (ro < 0) begin
      if (m_arvalid[0] || m_arvalid[1]) begin
        ro = (m_arvalid[0] && m_arvalid[1]) ? ((rprev == 1) ? 0 : 1) : (m_arvalid[0] ? 0 : 1);
        rph = 1'b0;
      end
    end else if (!rph) begin
      if (ar_hs) rph = 1'b1;
    end else if (r_hs) begin
      rprev = ro; ro = -1;
    end

    for (int i = 0; i < 2; i++) begin
      if (wa[i]) begin
        if (awp[i] && awd[i] > 0) awd[i]--;
        if (wp[i] && wd[i] > 0) wd[i]--;
      end else if ($urandom_range(0, 2) == 0) begin
        wa[i] = 1'b1; awp[i] = 1'b1; wp[i] = 1'b1;
        awd[i] = $urandom_range(0, 1) ? 0 : $urandom_range(1, 4);
        wd[i]  = $urandom_range(0, 1) ? 0 : $urandom_range(1, 4);
        maw[i] = AW'($urandom); mwd[i] = DW'($urandom); mws[i] = SW'($urandom);
      end
      if (!ra[i] && $urandom_range(0, 2) == 0) begin
        ra[i] = 1'b1; arp[i] = 1'b1; mar[i] = AW'($urandom);
      end
    end

    if (!iRST) reset_model();
  endtask

  initial begin
    reset_model();
    drive();
    repeat (2) @(posedge iCLK);
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge iCLK);
      iRST = ($urandom_range(0, 199) != 0);
      drive();
      #1;
      step_cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4_lite_arbiter_m2s1.md
# axi4_lite_arbiter_m2s1

Two-master to one-slave AXI4-Lite arbiter. It lets a second bus master, such as a DMA engine or debug loader, share the single master port of `axi4_lite_interconnect_m1s3` with the picorv32_axi core. The write path and the read path are arbitrated independently, each with two-way round-robin priority. Each path holds one transaction at a time, and the grant is held from the address phase until the response handshake completes.

## Interface
- `ADDR_WIDTH`, 32, address width on all ports
- `DATA_WIDTH`, 32, data width; strobe width is `DATA_WIDTH/8`

Ports:
- `iCLK`  in  1  system clock; all logic is on the rising edge
- `iRST`  in  1  synchronous reset, active-low
- `mN_AWVALID/AWADDR/AWREADY`, N=0,1  in/in/out  1/ADDR_WIDTH/1  upstream write-address channel
- `mN_WVALID/WDATA/WSTRB/WREADY`  in/in/in/out  1/DATA_WIDTH/DATA_WIDTH/8/1  upstream write-data channel
- `mN_BVALID/BRESP/BREADY`  out/out/in  1/2/1  upstream write-response channel
- `mN_ARVALID/ARADDR/ARREADY`  in/in/out  1/ADDR_WIDTH/1  upstream read-address channel
- `mN_RVALID/RDATA/RRESP/RREADY`  out/out/out/in  1/DATA_WIDTH/2/1  upstream read-data channel
- `s_AW*`, `s_W*`, `s_B*`, `s_AR*`, `s_R*`  mirror of the above  downstream port to interconnect `m0_*`
- `oWGNT`  out  2  one-hot write grant; `2'b00` when the write path is idle
- `oRGNT`  out  2  one-hot read grant; `2'b00` when the read path is idle

## Operation

**Write FSM states: W_IDLE, W_ADDR, W_RESP.**
- **W_IDLE.** Master N is requesting when `mN_AWVALID | mN_WVALID`.
  - One requester: grant it.
  - Both requesting: grant the master that is not `w_last`.
  - Register the grant, clear `aw_done` and `w_done`, then go to W_ADDR.
- **W_ADDR.**
  - `s_AWVALID = mG_AWVALID & ~aw_done`, and `s_WVALID = mG_WVALID & ~w_done`.
  - `mG_AWREADY` and `mG_WREADY` are routed back from the slave side, masked by the same done flags.
  - Each handshake sets its done flag.
  - When both flags are set (including both in the same cycle), go to W_RESP.
- **W_RESP.**
  - `mG_BVALID/BRESP` are forwarded from `s_BVALID/BRESP`, and `s_BREADY = mG_BREADY`.
  - On the B handshake: `w_last <= G`, clear the grant, go to W_IDLE.

**Read FSM states: R_IDLE, R_ADDR, R_DATA.** The structure matches the write FSM.
- **R_IDLE.** The request is `mN_ARVALID`; the round-robin pointer is `r_last`.
- **R_ADDR.** AR is forwarded until its handshake, then go to R_DATA.
- **R_DATA.** R is forwarded; on the R handshake, update `r_last`, clear the grant, go to R_IDLE.

**Output routing and isolation.**
- The non-granted master sees all READY and VALID outputs at 0, and its data/resp outputs at 0.
- While a path is idle, its `s_*VALID` and `s_*READY` outputs are 0.
- Downstream address, data and strobe are driven from the granted master, and are 0 when nothing is granted.

**Other rules.**
- Read and write paths never interact. Master 0 may hold the write grant while master 1 holds the read grant.
- Upstream masters must obey AXI rules: VALID stays asserted until handshake. The arbiter does not buffer payloads and passes them through combinationally.
- The slave's BRESP and RRESP are passed through unmodified.

## Timing
- **Reset values:** `iRST=0` at an edge puts both FSMs in IDLE, sets `w_last = r_last = 1` (so master 0 wins the first tie), clears the done flags, and drives every output to 0.
- **Reset mid-transaction:** the in-flight transaction is abandoned with no response; the downstream slaves reset on the same signal.
- **Grant latency:** a request seen in IDLE at edge k is forwarded downstream from cycle k+1. There is no combinational path from `mN_*VALID` to `s_*VALID` in IDLE.
- **Minimum write:** 3 cycles (IDLE, ADDR with AW and W accepted together, RESP with B accepted immediately). The next grant decision happens in the cycle after the B handshake.
- **Minimum read:** 3 cycles.
- **Request drops in IDLE:** if a request deasserts before the decision edge, no grant is issued.
- **No time-out:** a slave that never responds stalls that path indefinitely.
- **Combinational paths** are allowed only in the ADDR and RESP/DATA states, slave→master for READY/VALID/data and master→slave for VALID/READY/data. There are no loops, because each direction's READY never depends on its own VALID.

## Test plan
- **Single write:** m0 writes `0x0002_0000` with data `0x0000_00A5` and strobe `4'hF`; slave answers B=OKAY. Expect exactly one downstream AW and one W, `m0_BVALID` with BRESP `2'b00`, `oWGNT` sequence `00→01→01→00`, and m1 ready signals 0 throughout.
- **Tie and fairness:** m0 and m1 both assert AR at the same edge, repeated 4 times back-to-back. Expect grants in the order m0, m1, m0, m1; `m1_RDATA` matches the slave data for its address `0x1000_0004`.
- **W before AW:** m1 presents WVALID 3 cycles before AWVALID. Expect `s_WVALID` accepted first, `s_AWVALID` issued later, a single B to m1, and no duplicate W.
- **Concurrent paths:** m0 write to RAM `0x1000_0010` and m1 read from ROM `0x0000_0020` start in the same cycle. Expect `oWGNT=01` and `oRGNT=10` simultaneously, and both complete.
- **Backpressure:** slave holds AWREADY, WREADY, BREADY-side and RVALID low for 5 cycles. Expect the grant to stay held, no spurious handshake, and the payload to stay stable on `s_*`.
- **Reset mid-write:** assert `iRST=0` for 1 cycle while in W_RESP. Expect all outputs 0 on the next cycle and both FSMs in IDLE; a following m1-only write is granted m1 with no stale m0 response.
